// File: rtl/fft_bfly_add_pkg.sv
// Shared FFT definitions: datapath width helpers and twiddle-table constants.
package fft_bfly_add_pkg;

  // Twiddle factors for a 16-point transform, Q1.15, first quadrant (k = 0..3).
  localparam int TW_FRAC_BITS = 15;
  localparam logic signed [15:0] TW_COS [4] = '{16'sd32767, 16'sd30274, 16'sd23170, 16'sd12540};
  localparam logic signed [15:0] TW_SIN [4] = '{16'sd0, -16'sd12540, -16'sd23170, -16'sd30274};

  // Width of one twiddle product: one extra bit when the multiplier keeps
  // its compensation bit.
  function automatic int prod_w(input int dw, input bit compens);
    return compens ? dw + 1 : dw;
  endfunction

  // Width of one butterfly output: P+1 with full growth, P when halved.
  function automatic int out_w(input int p, input bit scale);
    return scale ? p : p + 1;
  endfunction

  // Width of an occupancy counter that must represent 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fft_bfly_add_if.sv
// Butterfly-adder bus: top-sample stream, twiddle-product strobe and results.
interface fft_bfly_add_if #(
  parameter int DW = 16,
  parameter int PW = 16,
  parameter int OW = 17,
  parameter int CW = 4
);

  logic                 top_valid;
  logic                 top_ready;
  logic signed [DW-1:0] top_i;
  logic signed [DW-1:0] top_q;

  logic                 prod_valid;
  logic signed [PW-1:0] prod_minus_i;
  logic signed [PW-1:0] prod_minus_q;
  logic signed [PW-1:0] prod_plus_i;
  logic signed [PW-1:0] prod_plus_q;

  logic signed [OW-1:0] out0_i;
  logic signed [OW-1:0] out0_q;
  logic signed [OW-1:0] out1_i;
  logic signed [OW-1:0] out1_q;
  logic                 out_valid;

  logic [CW-1:0]        fifo_count;
  logic                 underflow;

  modport master (
    output top_valid, top_i, top_q,
    output prod_valid, prod_minus_i, prod_minus_q, prod_plus_i, prod_plus_q,
    input  top_ready, out0_i, out0_q, out1_i, out1_q, out_valid,
    input  fifo_count, underflow
  );

  modport slave (
    input  top_valid, top_i, top_q,
    input  prod_valid, prod_minus_i, prod_minus_q, prod_plus_i, prod_plus_q,
    output top_ready, out0_i, out0_q, out1_i, out1_q, out_valid,
    output fifo_count, underflow
  );

endinterface

// File: rtl/fft_bfly_add_fifo.sv
// Top-sample buffer: synchronous FIFO with occupancy count.
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
module fft_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointers and occupancy; a simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Pointer and count registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (reset_n && do_push) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fft_bfly_add.sv
// Radix-2 butterfly adder: pairs each buffered top sample with the strobed
// +W*b / -W*b products and emits a+(-W*b) and a+(+W*b) two cycles later.
module fft_bfly_add
  import fft_bfly_add_pkg::*;
#(
  parameter int    DATA_FFT_SIZE = 16,
  parameter string COMPENS_FP    = "false",
  parameter string SCALE         = "false",
  parameter int    FIFO_DEPTH    = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  fft_bfly_add_if.slave  bus
);

  localparam bit COMP_ON  = (COMPENS_FP == "add");
  localparam bit SCALE_ON = (SCALE == "true");
  localparam int DW = DATA_FFT_SIZE;
  localparam int P  = prod_w(DW, COMP_ON);
  localparam int WO = out_w(P, SCALE_ON);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int FW = 2 * DW;

  logic          push, pop, full, empty;
  logic [FW-1:0] fifo_dout;
  logic [CW-1:0] count;

  // Stage 1: operands widened to P+1 so the stage-2 sums cannot overflow.
  // Index 0 = I, 1 = Q.
  logic signed [P:0] a_q  [2];
  logic signed [P:0] pm_q [2];
  logic signed [P:0] pp_q [2];
  logic              v1_q;
  logic              underflow_q;

  // Stage 2: 0 = out0_i, 1 = out0_q, 2 = out1_i, 3 = out1_q.
  logic signed [P:0]    sum   [4];
  logic signed [WO-1:0] res_d [4];
  logic signed [WO-1:0] res_q [4];
  logic                 out_valid_q;

  // No bypass: a product arriving while the buffer is empty is never paired,
  // even if a sample is pushed in the same cycle.
  assign push = bus.top_valid && !full;
  assign pop  = bus.prod_valid && !empty;

  fft_sample_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({bus.top_i, bus.top_q}),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Capture the oldest sample and the strobed products on each pop; flag orphans.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_q        <= 1'b0;
      underflow_q <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        a_q[k]  <= '0;
        pm_q[k] <= '0;
        pp_q[k] <= '0;
      end
    end else begin
      v1_q <= pop;
      if (bus.prod_valid && empty) underflow_q <= 1'b1;
      if (pop) begin
        a_q[0]  <= (P+1)'($signed(fifo_dout[FW-1 -: DW]));
        a_q[1]  <= (P+1)'($signed(fifo_dout[DW-1:0]));
        pm_q[0] <= (P+1)'(bus.prod_minus_i);
        pm_q[1] <= (P+1)'(bus.prod_minus_q);
        pp_q[0] <= (P+1)'(bus.prod_plus_i);
        pp_q[1] <= (P+1)'(bus.prod_plus_q);
      end
    end
  end

  // Butterfly sums in P+1 bits.
  always_comb begin
    sum[0] = a_q[0] + pm_q[0];
    sum[1] = a_q[1] + pm_q[1];
    sum[2] = a_q[0] + pp_q[0];
    sum[3] = a_q[1] + pp_q[1];
  end

  for (genvar k = 0; k < 4; k++) begin : g_ch
    if (SCALE_ON) begin : g_half
      // Round-half-up halving: (s + 1) >>> 1, done one bit wider to keep s+1 exact.
      logic signed [P+1:0] t;
      assign t        = (P+2)'(sum[k]) + (P+2)'(1);
      assign res_d[k] = WO'(t >>> 1);
    end else begin : g_full
      assign res_d[k] = sum[k];
    end
  end

  // Output registers; data holds between strobes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      for (int k = 0; k < 4; k++) res_q[k] <= '0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        for (int k = 0; k < 4; k++) res_q[k] <= res_d[k];
      end
    end
  end

  assign bus.top_ready  = !full;
  assign bus.fifo_count = count;
  assign bus.underflow  = underflow_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out0_i     = res_q[0];
  assign bus.out0_q     = res_q[1];
  assign bus.out1_i     = res_q[2];
  assign bus.out1_q     = res_q[3];

endmodule

// File: tb/tb_fft_bfly_add.sv
// Bench for fft_bfly_add: full-growth and halving instances driven identically,
// checked against a queue-based reference model plus directed vectors.
module tb_fft_bfly_add;

  localparam int DW    = 16;
  localparam int P     = 16;
  localparam int WOF   = 17;
  localparam int WOS   = 16;
  localparam int CW    = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fft_bfly_add_if #(.DW(DW), .PW(P), .OW(WOF), .CW(CW)) bus_f ();
  fft_bfly_add_if #(.DW(DW), .PW(P), .OW(WOS), .CW(CW)) bus_s ();

  assign bus_s.top_valid    = bus_f.top_valid;
  assign bus_s.top_i        = bus_f.top_i;
  assign bus_s.top_q        = bus_f.top_q;
  assign bus_s.prod_valid   = bus_f.prod_valid;
  assign bus_s.prod_minus_i = bus_f.prod_minus_i;
  assign bus_s.prod_minus_q = bus_f.prod_minus_q;
  assign bus_s.prod_plus_i  = bus_f.prod_plus_i;
  assign bus_s.prod_plus_q  = bus_f.prod_plus_q;

  fft_bfly_add #(.DATA_FFT_SIZE(16), .COMPENS_FP("false"), .SCALE("false"), .FIFO_DEPTH(8))
    u_f (.clk(clk), .reset_n(reset_n), .bus(bus_f));
  fft_bfly_add #(.DATA_FFT_SIZE(16), .COMPENS_FP("false"), .SCALE("true"), .FIFO_DEPTH(8))
    u_s (.clk(clk), .reset_n(reset_n), .bus(bus_s));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { int i; int q; } samp_t;
  typedef struct packed {
    int due;
    int f0i; int f0q; int f1i; int f1q;
    int s0i; int s0q; int s1i; int s1q;
  } exp_t;

  samp_t mq[$];
  exp_t  sb[$];
  exp_t  last;
  exp_t  e;
  samp_t a;
  int    ecount = 0;
  int    uf_m = 0;
  int    sz;
  int    exp_v;

  function automatic int half_up(input int s);
    int t;
    t = s + 1;
    return (t >= 0) ? t / 2 : -((1 - t) / 2);
  endfunction

  always @(posedge clk) begin
    ecount++;
    if (!reset_n) begin
      mq.delete();
      sb.delete();
      uf_m = 0;
      last = '0;
    end else begin
      sz = mq.size();
      if (bus_f.prod_valid && sz == 0) uf_m = 1;
      if (bus_f.prod_valid && sz > 0) begin
        a     = mq.pop_front();
        e.due = ecount + 1;
        e.f0i = a.i + int'(bus_f.prod_minus_i);
        e.f0q = a.q + int'(bus_f.prod_minus_q);
        e.f1i = a.i + int'(bus_f.prod_plus_i);
        e.f1q = a.q + int'(bus_f.prod_plus_q);
        e.s0i = half_up(e.f0i);
        e.s0q = half_up(e.f0q);
        e.s1i = half_up(e.f1i);
        e.s1q = half_up(e.f1q);
        sb.push_back(e);
      end
      if (bus_f.top_valid && sz < DEPTH) begin
        a.i = int'(bus_f.top_i);
        a.q = int'(bus_f.top_q);
        mq.push_back(a);
      end
    end
  end

  always @(negedge clk) begin
    if (ecount > 0) begin
      chk("fifo_count", int'(bus_f.fifo_count), mq.size());
      chk("top_ready", int'(bus_f.top_ready), (mq.size() < DEPTH) ? 1 : 0);
      chk("underflow", int'(bus_f.underflow), uf_m);
      chk("underflow_s", int'(bus_s.underflow), uf_m);
      exp_v = 0;
      if (sb.size() > 0 && sb[0].due == ecount) begin
        last  = sb.pop_front();
        exp_v = 1;
      end
      chk("out_valid", int'(bus_f.out_valid), exp_v);
      chk("out_valid_s", int'(bus_s.out_valid), exp_v);
      chk("out0_i", int'(bus_f.out0_i), last.f0i);
      chk("out0_q", int'(bus_f.out0_q), last.f0q);
      chk("out1_i", int'(bus_f.out1_i), last.f1i);
      chk("out1_q", int'(bus_f.out1_q), last.f1q);
      chk("out0_i_s", int'(bus_s.out0_i), last.s0i);
      chk("out0_q_s", int'(bus_s.out0_q), last.s0q);
      chk("out1_i_s", int'(bus_s.out1_i), last.s1i);
      chk("out1_q_s", int'(bus_s.out1_q), last.s1q);
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int ai; int aq; int pmi; int pmq; int ppi; int ppq;
    int f0i; int f0q; int f1i; int f1q;
    int s0i; int s0q; int s1i; int s1q;
  } vec_t;
  vec_t vt [4];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus_f.top_valid    = 1'b0;
    bus_f.top_i        = '0;
    bus_f.top_q        = '0;
    bus_f.prod_valid   = 1'b0;
    bus_f.prod_minus_i = '0;
    bus_f.prod_minus_q = '0;
    bus_f.prod_plus_i  = '0;
    bus_f.prod_plus_q  = '0;
  endtask

  task automatic set_top(input int ai, input int aq);
    bus_f.top_valid = 1'b1;
    bus_f.top_i     = DW'(ai);
    bus_f.top_q     = DW'(aq);
  endtask

  task automatic set_prod(input int pmi, input int pmq, input int ppi, input int ppq);
    bus_f.prod_valid   = 1'b1;
    bus_f.prod_minus_i = P'(pmi);
    bus_f.prod_minus_q = P'(pmq);
    bus_f.prod_plus_i  = P'(ppi);
    bus_f.prod_plus_q  = P'(ppq);
  endtask

  task automatic pulse_reset();
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    vt[0] = '{100, -50, 30, 20, -30, -20, 130, -30, 70, -70, 65, -15, 35, -35};
    vt[1] = '{3, 0, 2, 0, -2, 0, 5, 0, 1, 0, 3, 0, 1, 0};
    vt[2] = '{-32768, 32767, -32768, 32767, 32767, -32768, -65536, 65534, -1, -1, -32768, 32767, 0, 0};
    vt[3] = '{-7, 7, 0, -1, -1, 0, -7, 6, -8, 7, -3, 3, -4, 4};

    idle();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_top_ready", int'(bus_f.top_ready), 1);
    chk("rst_fifo_count", int'(bus_f.fifo_count), 0);
    chk("rst_out_valid", int'(bus_f.out_valid), 0);
    chk("rst_out0_i", int'(bus_f.out0_i), 0);
    chk("rst_underflow", int'(bus_f.underflow), 0);
    step();

    // Directed vectors: push, strobe, result two cycles after the strobe.
    for (int k = 0; k < 4; k++) begin
      set_top(vt[k].ai, vt[k].aq);
      step();
      idle();
      set_prod(vt[k].pmi, vt[k].pmq, vt[k].ppi, vt[k].ppq);
      step();
      idle();
      @(negedge clk);
      chk($sformatf("vec%0d_early_valid", k), int'(bus_f.out_valid), 0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", k), int'(bus_f.out_valid), 1);
      chk($sformatf("vec%0d_out0_i", k), int'(bus_f.out0_i), vt[k].f0i);
      chk($sformatf("vec%0d_out0_q", k), int'(bus_f.out0_q), vt[k].f0q);
      chk($sformatf("vec%0d_out1_i", k), int'(bus_f.out1_i), vt[k].f1i);
      chk($sformatf("vec%0d_out1_q", k), int'(bus_f.out1_q), vt[k].f1q);
      chk($sformatf("vec%0d_s_out0_i", k), int'(bus_s.out0_i), vt[k].s0i);
      chk($sformatf("vec%0d_s_out0_q", k), int'(bus_s.out0_q), vt[k].s0q);
      chk($sformatf("vec%0d_s_out1_i", k), int'(bus_s.out1_i), vt[k].s1i);
      chk($sformatf("vec%0d_s_out1_q", k), int'(bus_s.out1_q), vt[k].s1q);
      @(negedge clk);
      chk($sformatf("vec%0d_valid_drop", k), int'(bus_f.out_valid), 0);
      chk($sformatf("vec%0d_hold", k), int'(bus_f.out0_i), vt[k].f0i);
      step();
    end

    // Fill to full, refuse a ninth push, drain, then overlapped push/pop across the wrap.
    for (int i = 0; i < 9; i++) begin
      set_top(i * 10 + 1, -i);
      step();
    end
    idle();
    @(negedge clk);
    chk("full_count", int'(bus_f.fifo_count), 8);
    chk("full_ready", int'(bus_f.top_ready), 0);
    step();
    for (int i = 0; i < 8; i++) begin
      set_prod(i, 0, 0, i);
      step();
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("drain_last_out0_i", int'(bus_f.out0_i), 71 + 7);
    chk("drain_last_out1_q", int'(bus_f.out1_q), -7 + 7);
    step();
    for (int j = 0; j < 9; j++) begin
      idle();
      if (j < 8) set_top(1000 + j, 2000 - j);
      if (j >= 1) set_prod(j, -j, -j, j);
      step();
    end
    idle();
    repeat (3) step();
    @(negedge clk);
    chk("wrap_end_count", int'(bus_f.fifo_count), 0);
    chk("wrap_last_out0_i", int'(bus_f.out0_i), 1007 + 8);

    // Underflow: empty strobe, then same-cycle push and strobe.
    pulse_reset();
    step();
    set_prod(5, 5, 5, 5);
    step();
    idle();
    @(negedge clk);
    chk("uf_set", int'(bus_f.underflow), 1);
    step();
    set_top(9, 9);
    set_prod(1, 1, 1, 1);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("uf_no_out_valid", int'(bus_f.out_valid), 0);
      chk("uf_sticky", int'(bus_f.underflow), 1);
      chk("uf_count_after_push", int'(bus_f.fifo_count), 1);
    end
    step();

    // Reset with three samples buffered and one product in flight.
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      set_top(i + 1, i + 1);
      step();
    end
    idle();
    set_prod(1, 1, 1, 1);
    step();
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_out_valid", int'(bus_f.out_valid), 0);
      chk("rst_mid_count", int'(bus_f.fifo_count), 0);
      chk("rst_mid_underflow", int'(bus_f.underflow), 0);
    end
    step();

    // Random traffic against the model.
    pulse_reset();
    for (int c = 0; c < 800; c++) begin
      idle();
      if ($urandom_range(0, 99) < 60) begin
        if ($urandom_range(0, 15) == 0) set_top(-32768, 32767);
        else set_top(int'($urandom), int'($urandom));
      end
      if ($urandom_range(0, 99) < 55) begin
        if ($urandom_range(0, 15) == 0) set_prod(-32768, 32767, 32767, -32768);
        else set_prod(int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      end
      step();
    end
    idle();
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bfly_add.md
FFT_BFLY_ADD -- requirements
Module: fft_bfly_add

Interface
REQ-001 Parameter DATA_FFT_SIZE, default 16, width of the top-sample I/Q.
REQ-002 Parameter COMPENS_FP, default "false", twiddle-product format. "add" means products are DATA_FFT_SIZE+1 bits; any other value means DATA_FFT_SIZE bits. Product width is denoted P.
REQ-003 Parameter SCALE, default "false", per-stage halving. "true" halves outputs; "false" keeps full growth.
REQ-004 Parameter FIFO_DEPTH, default 8, top-sample buffer depth. It shall be a power of 2, at least 2.
REQ-005 Output width WO shall be P+1 when SCALE is "false" and P when SCALE is "true".
REQ-006 clk  in  1  sole clock; all logic on posedge.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 top_valid  in  1  top sample (a) present.
REQ-009 top_i, top_q  in  DATA_FFT_SIZE each  signed top sample.
REQ-010 top_ready  out  1  buffer can accept a; high when not full.
REQ-011 prod_valid  in  1  single-cycle strobe marking a twiddle-product pair.
REQ-012 prod_minus_i, prod_minus_q, prod_plus_i, prod_plus_q  in  P each  signed +W·b and −W·b.
REQ-013 out0_i, out0_q, out1_i, out1_q  out  WO each  butterfly results.
REQ-014 out_valid  out  1  single-cycle strobe marking a result pair.
REQ-015 fifo_count  out  log2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-016 underflow  out  1  sticky flag: a product arrived with no matching top sample.

Function
REQ-017 Push shall occur when top_valid && top_ready; samples shall be stored in arrival order.
REQ-018 Pop shall occur when prod_valid && fifo_count != 0. Each pop pairs the oldest a with the strobed products.
REQ-019 On a same-cycle push and pop, fifo_count shall be unchanged. At full, top_ready is low, so a same-cycle push is refused even when a pop occurs.
REQ-020 There shall be no bypass: a push and a prod_valid in the same cycle with an empty buffer is an underflow event.
REQ-021 On an underflow event: set underflow, drop the product, leave out_valid low, and keep the read pointer unchanged.
REQ-022 Read and write pointers shall wrap modulo FIFO_DEPTH.
REQ-023 Stage 1, on pop: register a sign-extended to P+1 bits and both products sign-extended to P+1 bits, plus a valid bit v1.
REQ-024 Stage 2 shall compute s0 = a + prod_minus and s1 = a + prod_plus per I and Q, in P+1 bits with no overflow possible.
REQ-025 With SCALE "false", out0 = s0 and out1 = s1, full width.
REQ-026 With SCALE "true", out = (s + 1) >>> 1 (arithmetic shift), truncated to P bits.
REQ-027 Outputs shall be registered. out_valid shall assert exactly 2 cycles after the accepted prod_valid edge and last 1 cycle.
REQ-028 Back-to-back prod_valid strobes in consecutive cycles shall produce consecutive out_valid strobes, giving throughput of 1 pair/cycle.
REQ-029 Data outputs shall hold their last value while out_valid is low.
REQ-030 underflow shall clear only on reset.

Reset
REQ-031 With reset_n low at a posedge, the following shall be cleared: pointers, fifo_count=0, pipeline valid bits, out_valid=0, underflow=0, all out*=0.
REQ-032 top_ready shall be 1 after reset.
REQ-033 Reset mid-operation shall discard buffered samples and in-flight results; no out_valid shall follow the reset.
REQ-034 While reset_n is low, inputs shall be ignored.

Structure
REQ-035 The width functions (P, WO, counter width) shall live in the shared FFT package alongside the twiddle-table constants.
REQ-036 The top-sample buffer shall be one sub-module, fft_sample_fifo, parameterised by width and depth. It exposes push, pop, full, empty and count.
REQ-037 Adders and scaling shall stay in fft_bfly_add; no DSP primitive is required.

Verification
REQ-038 Basic pair, defaults: push a=(100,−50); strobe prod_minus=(30,20) and prod_plus=(−30,−20). Required: 2 cycles later out0=(130,−30), out1=(70,−70), out_valid=1 for 1 cycle.
REQ-039 SCALE "true": a=(3,0), prod_minus=(2,0), prod_plus=(−2,0). Required: out0_i=3 ((5+1)>>>1) and out1_i=1 ((1+1)>>>1).
REQ-040 Extremes, DATA_FFT_SIZE=16, SCALE "false": a_i=−32768, prod_minus_i=−32768. Required: out0_i=−65536 with no wrap.
REQ-041 Fill and wrap: push 8 samples. Required: top_ready=0 and fifo_count=8; a 9th push is ignored. Then 8 strobes, then 8 more pushes and strobes. Required: outputs in FIFO order, fifo_count=0 at end.
REQ-042 Underflow: strobe prod_valid with an empty buffer, including the case of a same-cycle push. Required: underflow=1 and stays 1, no out_valid, fifo_count=1 after the same-cycle push.
REQ-043 Reset mid-flight: 3 samples buffered and 1 strobe issued, then reset_n low for 1 cycle. Required: fifo_count=0, out_valid never asserts, underflow=0.
